fpu_issue_seq: RTL and testbench
================================

Name: fpu_issue_seq

Overview:
- Issue/retire sequencer between the integer core's decode/execute stage and the FPU arithmetic datapath.
- Accepts an FPU op from the core and stalls the core for that op's latency.
- Captures the datapath result and exception flags into an output register, then presents them to writeback with a one-cycle valid pulse.
- Supports flush (kill) of an in-flight op.

Parameters:
- MUL_LAT, 2: cycles for ops 5'b0001? and 5'b01011.
- DIV_LAT, 24: cycles for ops 5'b01100 (div) and 5'b01101 (sqrt); legal range 2..63.
- XLEN, 32: result width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  core presents an FPU op; held high by the core while stall=1.
- op  in  5  FPU operation code.
- kill  in  1  flush; aborts any in-flight op.
- res_in  in  XLEN  datapath result.
- flags_in  in  5  datapath fflags (NV,DZ,OF,UF,NX).
- busy  out  1  sequencer is not IDLE.
- stall  out  1  freeze core pipeline.
- valid  out  1  result/fflags valid, one-cycle pulse.
- result  out  XLEN  registered result.
- fflags  out  5  registered flags.
- op_q  out  5  latched op, steers datapath muxes.

Behaviour:
- Reset: synchronous, active-low. While reset=0 at a clk edge, all of the following are cleared: state=IDLE, cnt=0, op_q=0, result=0, fflags=0. valid=0, stall=0, busy=0 in the following cycle.
- Latency lookup lat(op):
  - MUL_LAT for 0001? and 01011.
  - DIV_LAT for 01100 and 01101.
  - 1 for all other ops.
- States are IDLE, EXEC and DONE.
- IDLE:
  - stall = start & ~kill.
  - On start & ~kill: op_q<=op, cnt<=lat(op)-1.
    - If lat(op)==1: capture result/fflags from res_in/flags_in this edge and go to DONE.
    - Otherwise go to EXEC.
- EXEC:
  - stall=1, busy=1.
  - cnt decrements each cycle.
  - When cnt==1: capture res_in/flags_in and go to DONE.
- DONE:
  - valid=1, stall=0, busy=1.
  - Next state is always IDLE.
  - start is ignored in this cycle: it is the same instruction's tail, and the core advances at the end of DONE.
- Total stall cycles for an op of latency L equals L. valid asserts L cycles after the accepting edge.
- result/fflags hold their value until the next capture, so they stay stable after valid drops.
- kill:
  - In any state, go to IDLE next edge with no valid and cnt=0; stall deasserts combinationally.
  - result/fflags are not updated.
  - kill together with start in IDLE: the op is not accepted.
- op changing during EXEC is ignored; op_q is authoritative.
- start dropping during EXEC without kill: the op completes normally, which is a protocol violation that the bench flags.
- Reset mid-operation behaves like kill and also clears result/fflags.

Optional Feature:
- Macro FPU_SEQ_PERF_CNT_EN.
- When defined, the block adds outputs busy_cycles[31:0] and op_count[31:0]:
  - busy_cycles increments every cycle stall=1.
  - op_count increments on every valid.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package fpu_seq_pkg holds:
  - op-code constants (OP_MUL_GRP, OP_FMA, OP_DIV, OP_SQRT);
  - state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2);
  - the lat(op) function;
  - CNT_W = $clog2(DIV_LAT+1).
- One sub-module, fpu_lat_counter: loadable down-counter with load, dec, clr inputs and cnt and at_one outputs.

Test Plan:
- Single-cycle op: op=5'b00000, start=1 one cycle, res_in=32'h3F80_0000 → stall high that cycle only, valid high next cycle, result=32'h3F80_0000.
- Mul op: op=5'b00010 with MUL_LAT=2 → stall high 2 cycles, valid at cycle 2, fflags=flags_in sampled at the final EXEC edge (e.g. 5'b00001).
- Div op: op=5'b01100 with DIV_LAT=24 → stall high 24 cycles, exactly one valid pulse; start held in DONE does not re-issue.
- Kill at EXEC cycle 10 of a div → IDLE next edge, no valid, result keeps its prior value; a new add issued next cycle completes normally.
- Synchronous reset asserted mid-EXEC → outputs cleared at that edge; asserting reset between edges has no effect until the edge.
- Back-to-back ops: mul immediately followed by add → two valid pulses separated by the DONE→IDLE bubble, results in order.

Source files
------------

// File: rtl/fpu_issue_seq_pkg.sv
// Shared op-code constants, FSM encoding and latency lookup for the FPU issue sequencer.
package fpu_seq_pkg;

    localparam logic [3:0] OP_MUL_GRP = 4'b0001;
    localparam logic [4:0] OP_FMA     = 5'b01011;
    localparam logic [4:0] OP_DIV     = 5'b01100;
    localparam logic [4:0] OP_SQRT    = 5'b01101;

    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_DIV_LAT = 24;
    localparam int CNT_W       = $clog2(DEF_DIV_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int lat(input logic [4:0] op, input int mul_lat, input int div_lat);
        if (op[4:1] == OP_MUL_GRP || op == OP_FMA) begin
            return mul_lat;
        end else if (op == OP_DIV || op == OP_SQRT) begin
            return div_lat;
        end
        return 1;
    endfunction

endpackage

// File: rtl/fpu_issue_seq_if.sv
// Core <-> sequencer bundle: issue request, flush, datapath return and writeback outputs.
interface fpu_issue_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      op;
    logic            kill;
    logic [XLEN-1:0] res_in;
    logic [4:0]      flags_in;
    logic            busy;
    logic            stall;
    logic            valid;
    logic [XLEN-1:0] result;
    logic [4:0]      fflags;
    logic [4:0]      op_q;

    modport master (
        output start, op, kill, res_in, flags_in,
        input  busy, stall, valid, result, fflags, op_q
    );

    modport slave (
        input  start, op, kill, res_in, flags_in,
        output busy, stall, valid, result, fflags, op_q
    );
endinterface

// File: rtl/fpu_issue_seq_lat_counter.sv
// Loadable down-counter timing an in-flight FPU op; clr has priority over load, load over dec.
module fpu_lat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_one
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt    = r_cnt;
    assign at_one = (r_cnt == W'(1));
endmodule

// File: rtl/fpu_issue_seq.sv
// Issue/retire sequencer: stalls the core for an FPU op's latency, then pulses valid with the captured result.
// Optional perf counters (busy_cycles, op_count) exist only when FPU_SEQ_PERF_CNT_EN is defined.
module fpu_issue_seq
    import fpu_seq_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int XLEN    = 32
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FPU_SEQ_PERF_CNT_EN
    output logic [31:0] busy_cycles,
    output logic [31:0] op_count,
`endif
    fpu_issue_seq_if.slave bus
);
    localparam int LCNT_W = $clog2(DIV_LAT + 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [4:0]        r_op_q;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_fflags;

    logic              w_load;
    logic              w_dec;
    logic              w_clr;
    logic              w_capture;
    logic              w_lat_one;
    logic [LCNT_W-1:0] w_load_val;
    logic [LCNT_W-1:0] w_cnt;
    logic              w_at_one;
    int                w_lat;

    assign w_lat      = lat(bus.op, MUL_LAT, DIV_LAT);
    assign w_lat_one  = (w_lat == 1);
    assign w_load_val = LCNT_W'(w_lat - 1);

    fpu_lat_counter #(.W(LCNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .clr      (w_clr),
        .cnt      (w_cnt),
        .at_one   (w_at_one)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_clr       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    w_load = 1'b1;
                    if (w_lat_one) begin
                        w_capture   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                if (bus.kill) begin
                    w_clr       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_dec = 1'b1;
                    // cnt==0 can only be reached through a bad load; exit rather than hang the core
                    if (w_at_one || w_cnt == '0) begin
                        w_capture   = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_clr       = bus.kill;
                w_state_nxt = IDLE;
            end
            default: begin
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op_q   <= '0;
            r_result <= '0;
            r_fflags <= '0;
        end else begin
            if (r_state == IDLE && bus.start && !bus.kill) begin
                r_op_q <= bus.op;
            end
            if (w_capture) begin
                r_result <= bus.res_in;
                r_fflags <= bus.flags_in;
            end
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.stall  = !bus.kill && ((r_state == IDLE && bus.start) || r_state == EXEC);
    assign bus.valid  = (r_state == DONE) && !bus.kill;
    assign bus.result = r_result;
    assign bus.fflags = r_fflags;
    assign bus.op_q   = r_op_q;

`ifdef FPU_SEQ_PERF_CNT_EN
    logic [31:0] r_busy_cycles;
    logic [31:0] r_op_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy_cycles <= '0;
            r_op_count    <= '0;
        end else begin
            if (bus.stall && r_busy_cycles != 32'hFFFF_FFFF) begin
                r_busy_cycles <= r_busy_cycles + 32'd1;
            end
            if (bus.valid && r_op_count != 32'hFFFF_FFFF) begin
                r_op_count <= r_op_count + 32'd1;
            end
        end
    end

    assign busy_cycles = r_busy_cycles;
    assign op_count    = r_op_count;
`endif
endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq: single-cycle, mul, div, kill, sync reset and back-to-back ops.
module tb_fpu_issue_seq;
    logic clk = 1'b0;
    logic reset;
    int   neval = 0;
    int   nfail = 0;
    int   viol  = 0;

    fpu_issue_seq_if #(.XLEN(32)) bus ();

`ifdef FPU_SEQ_PERF_CNT_EN
    logic [31:0] busy_cycles;
    logic [31:0] op_count;
`endif

    fpu_issue_seq #(.MUL_LAT(2), .DIV_LAT(24), .XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef FPU_SEQ_PERF_CNT_EN
        .busy_cycles (busy_cycles),
        .op_count    (op_count),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // The core must hold start while the op is executing unless it flushes.
    always @(negedge clk) begin
        if (reset && bus.busy && !bus.valid && !bus.start && !bus.kill) viol++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        neval++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int sc;
        int vc;
        int vidx;
        logic busy_after;
        logic [4:0] opq_at_valid;

        reset = 1'b0;
        bus.start = 1'b0; bus.op = 5'd0; bus.kill = 1'b0;
        bus.res_in = '0; bus.flags_in = '0;
        step(); step();
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_stall",  32'(bus.stall),  32'd0);
        chk("rst_valid",  32'(bus.valid),  32'd0);
        chk("rst_result", bus.result,      32'd0);
        chk("rst_fflags", 32'(bus.fflags), 32'd0);
        chk("rst_opq",    32'(bus.op_q),   32'd0);
        reset = 1'b1;
        step();

        // single-cycle op
        bus.op = 5'b00000; bus.start = 1'b1; bus.res_in = 32'h3F80_0000; bus.flags_in = 5'b00000;
        #1;
        chk("s1_stall", 32'(bus.stall), 32'd1);
        step();
        chk("s1_valid",  32'(bus.valid), 32'd1);
        chk("s1_stall2", 32'(bus.stall), 32'd0);
        chk("s1_busy",   32'(bus.busy),  32'd1);
        chk("s1_result", bus.result,     32'h3F80_0000);
        bus.start = 1'b0;
        step();
        chk("s1_valid_drop", 32'(bus.valid), 32'd0);
        chk("s1_busy_drop",  32'(bus.busy),  32'd0);
        chk("s1_result_hold", bus.result,    32'h3F80_0000);

        // mul op, latency 2
        bus.op = 5'b00010; bus.start = 1'b1; bus.res_in = 32'h4000_0000; bus.flags_in = 5'b00000;
        #1;
        chk("mul_stall0", 32'(bus.stall), 32'd1);
        step();
        chk("mul_stall1", 32'(bus.stall), 32'd1);
        chk("mul_valid1", 32'(bus.valid), 32'd0);
        chk("mul_opq",    32'(bus.op_q),  32'b00010);
        bus.res_in = 32'h4040_0000; bus.flags_in = 5'b00001;
        step();
        chk("mul_valid",  32'(bus.valid),  32'd1);
        chk("mul_stall2", 32'(bus.stall),  32'd0);
        chk("mul_result", bus.result,      32'h4040_0000);
        chk("mul_fflags", 32'(bus.fflags), 32'b00001);
        bus.start = 1'b0;
        step();

        // div op, latency 24; op changes mid-flight and start is held into DONE
        bus.op = 5'b01100; bus.start = 1'b1; bus.res_in = 32'h2222_2222; bus.flags_in = 5'b00010;
        sc = 0; vc = 0; vidx = -100; busy_after = 1'bx; opq_at_valid = 5'bx;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.stall) sc++;
            if (i == vidx + 1) busy_after = bus.busy;
            if (bus.valid) begin
                vc++;
                vidx = i;
                opq_at_valid = bus.op_q;
            end
            if (i == 5) bus.op = 5'b00000;
            step();
            if (vidx == i) bus.start = 1'b0;
        end
        chk("div_stall_cycles", 32'(sc),     32'd24);
        chk("div_valid_count",  32'(vc),     32'd1);
        chk("div_valid_cycle",  32'(vidx),   32'd24);
        chk("div_no_reissue",   32'(busy_after), 32'd0);
        chk("div_opq",          32'(opq_at_valid), 32'b01100);
        chk("div_result",       bus.result,  32'h2222_2222);
        chk("div_fflags",       32'(bus.fflags), 32'b00010);

        // kill at EXEC cycle 10 of a div
        bus.op = 5'b01100; bus.start = 1'b1; bus.res_in = 32'h3333_3333; bus.flags_in = 5'b11111;
        #1;
        step();
        repeat (9) step();
        chk("kill_pre_busy", 32'(bus.busy), 32'd1);
        bus.kill = 1'b1;
        #1;
        chk("kill_stall_comb", 32'(bus.stall), 32'd0);
        chk("kill_valid_comb", 32'(bus.valid), 32'd0);
        step();
        chk("kill_busy",   32'(bus.busy),   32'd0);
        chk("kill_valid",  32'(bus.valid),  32'd0);
        chk("kill_result", bus.result,      32'h2222_2222);
        chk("kill_fflags", 32'(bus.fflags), 32'b00010);
        bus.kill = 1'b0; bus.op = 5'b00000; bus.res_in = 32'h4444_4444; bus.flags_in = 5'b10000;
        step();
        chk("post_kill_valid",  32'(bus.valid),  32'd1);
        chk("post_kill_result", bus.result,      32'h4444_4444);
        chk("post_kill_fflags", 32'(bus.fflags), 32'b10000);
        bus.start = 1'b0;
        step();

        // kill together with start in IDLE: not accepted
        bus.start = 1'b1; bus.kill = 1'b1; bus.op = 5'b00010;
        #1;
        chk("killst_stall", 32'(bus.stall), 32'd0);
        step();
        chk("killst_busy", 32'(bus.busy), 32'd0);
        chk("killst_opq",  32'(bus.op_q), 32'b00000);
        bus.kill = 1'b0; bus.start = 1'b0;
        step();

        // synchronous reset mid-EXEC; a pulse between edges has no effect
        bus.op = 5'b01101; bus.start = 1'b1; bus.res_in = 32'h5555_5555; bus.flags_in = 5'b00100;
        #1;
        step();
        step();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step();
        chk("rglitch_busy",   32'(bus.busy),  32'd1);
        chk("rglitch_stall",  32'(bus.stall), 32'd1);
        chk("rglitch_result", bus.result,     32'h4444_4444);
        reset = 1'b0; bus.start = 1'b0;
        step();
        chk("rmid_busy",   32'(bus.busy),   32'd0);
        chk("rmid_stall",  32'(bus.stall),  32'd0);
        chk("rmid_valid",  32'(bus.valid),  32'd0);
        chk("rmid_result", bus.result,      32'd0);
        chk("rmid_fflags", 32'(bus.fflags), 32'd0);
        chk("rmid_opq",    32'(bus.op_q),   32'd0);
        reset = 1'b1;
        step();

        // back-to-back fma then add
        bus.op = 5'b01011; bus.start = 1'b1; bus.res_in = 32'h6666_6666; bus.flags_in = 5'b00100;
        #1;
        step();
        step();
        chk("b2b_valid1",  32'(bus.valid),  32'd1);
        chk("b2b_result1", bus.result,      32'h6666_6666);
        chk("b2b_fflags1", 32'(bus.fflags), 32'b00100);
        bus.op = 5'b00000; bus.res_in = 32'h7777_7777; bus.flags_in = 5'b00000;
        step();
        chk("b2b_bubble_valid", 32'(bus.valid), 32'd0);
        chk("b2b_bubble_busy",  32'(bus.busy),  32'd0);
        chk("b2b_bubble_stall", 32'(bus.stall), 32'd1);
        step();
        chk("b2b_valid2",  32'(bus.valid),  32'd1);
        chk("b2b_result2", bus.result,      32'h7777_7777);
        chk("b2b_fflags2", 32'(bus.fflags), 32'b00000);
        bus.start = 1'b0;
        step();
        chk("b2b_idle_valid", 32'(bus.valid), 32'd0);

`ifdef FPU_SEQ_PERF_CNT_EN
        chk("perf_busy_cycles", busy_cycles, 32'd3);
        chk("perf_op_count",    op_count,    32'd2);
`endif

        chk("protocol_violations", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", neval, nfail);
        $finish;
    end
endmodule
